// File: rtl/onehot_code_tx.sv
`default_nettype none
// ============================================================================
// Module   : onehot_code_tx
// Purpose  : Accepts a request vector over a valid/ready handshake and emits
//            the binary index of every set bit, lowest index first, one code
//            per output beat. An all-zero vector yields one beat flagged
//            empty so the downstream decoder always sees a terminating beat.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            in_valid/in_ready  - input handshake, in_vec request vector
//            out_valid/out_ready- output handshake
//            out_code           - index of lowest pending bit
//            out_last           - final beat of the current vector
//            out_empty          - beat carries no code (vector was zero)
//            busy               - a vector is held, not fully transmitted
// Revision : 1.0 - initial release
// ============================================================================
module onehot_code_tx #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_code,
    output logic          out_last,
    output logic          out_empty,
    output logic          busy
);

    // One-hot style encoding so that illegal patterns exist and are
    // steered back to IDLE by the default decode path.
    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_SEND = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_pend;
    logic [W-1:0]   w_pend_nxt;
    logic           r_empty;
    logic           w_empty_nxt;

    logic [CW-1:0]  w_low_code;
    logic [W-1:0]   w_pend_clr;
    logic           w_multi;

    // Priority encode: scanning from the top down lets the lowest set bit
    // win. Defaults to 0 when nothing is pending.
    always_comb begin
        w_low_code = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_code = CW'(i);
            end
        end
    end

    // Clearing the lowest set bit; anything left over means more beats follow.
    assign w_pend_clr = r_pend & (r_pend - W'(1));
    assign w_multi    = |w_pend_clr;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_empty_nxt = r_empty;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_code    = '0;
        out_last    = 1'b0;
        out_empty   = 1'b0;
        busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_SEND;
                    w_pend_nxt  = in_vec;
                    w_empty_nxt = (in_vec == '0);
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_code  = w_low_code;
                out_last  = !w_multi;
                out_empty = r_empty;
                busy      = 1'b1;
                if (out_ready) begin
                    w_pend_nxt = w_pend_clr;
                    if (!w_multi) begin
                        w_state_nxt = S_IDLE;
                        w_empty_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = '0;
                w_empty_nxt = 1'b0;
            end
        endcase

        // Outputs are forced quiet for the whole reset cycle so no
        // handshake can complete while the state is being cleared.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_code  = '0;
            out_last  = 1'b0;
            out_empty = 1'b0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_empty <= w_empty_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_code_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_code_tx
// Purpose  : Directed self-checking bench for onehot_code_tx (W=8 and W=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_code_tx;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_code;
    logic        out_last;
    logic        out_empty;
    logic        busy;

    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] in_vec64;
    logic        out_valid64;
    logic        out_ready64;
    logic [5:0]  out_code64;
    logic        out_last64;
    logic        out_empty64;
    logic        busy64;

    int checks;
    int errors;

    onehot_code_tx #(.W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_empty (out_empty),
        .busy      (busy)
    );

    onehot_code_tx #(.W(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_vec    (in_vec64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_code  (out_code64),
        .out_last  (out_last64),
        .out_empty (out_empty64),
        .busy      (busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of the 8-bit instance: {valid, in_ready, busy, last, empty, code}
    logic [7:0] obs;
    assign obs = {out_valid, in_ready, busy, out_last, out_empty, out_code};

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_vec = 8'h33; out_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'b0);
        end
        checks++;
        if ({in_ready64, out_valid64, out_code64, out_last64, out_empty64, busy64} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs64: got %b expected 0",
                     {in_ready64, out_valid64, out_code64, out_last64, out_empty64, busy64});
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_mid_vector();
        logic [2:0] exp_code [3];
        exp_code = '{3'd0, 3'd2, 3'd5};
        @(negedge clk);
        in_vec = 8'b0010_0101; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== {1'b1, 1'b0, 1'b1, (k == 2), 1'b0, exp_code[k]}) begin
                errors++;
                $display("FAIL mid_vector_beat%0d: got %b expected %b", k, obs,
                         {1'b1, 1'b0, 1'b1, (k == 2), 1'b0, exp_code[k]});
            end
            @(negedge clk); #1;
        end
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL mid_vector_idle: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_backpressure();
        logic       rdy      [5];
        logic [2:0] exp_code [5];
        logic       exp_last [5];
        int         hs;
        rdy      = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_code = '{3'd1, 3'd1, 3'd7, 3'd7, 3'd7};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        hs = 0;
        @(negedge clk);
        in_vec = 8'b1000_0010; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            out_ready = rdy[k];
            #1;
            checks++;
            if (obs !== {1'b1, 1'b0, 1'b1, exp_last[k], 1'b0, exp_code[k]}) begin
                errors++;
                $display("FAIL backpressure_cycle%0d: got %b expected %b", k, obs,
                         {1'b1, 1'b0, 1'b1, exp_last[k], 1'b0, exp_code[k]});
            end
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        if (out_valid && out_ready) hs++;
        checks++;
        if (hs !== 2) begin
            errors++;
            $display("FAIL backpressure_handshakes: got %0d expected %0d", hs, 2);
        end
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL backpressure_idle: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        in_vec = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b1011_1000) begin
            errors++;
            $display("FAIL zero_beat: got %b expected %b", obs, 8'b1011_1000);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL zero_idle: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_full();
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk);
        in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs !== {1'b1, 1'b0, 1'b1, (k == 7), 1'b0, 3'(k)}) begin
                errors++;
                $display("FAIL full_beat%0d: got %b expected %b", k, obs,
                         {1'b1, 1'b0, 1'b1, (k == 7), 1'b0, 3'(k)});
            end
            if (busy) busy_cycles++;
            @(negedge clk); #1;
        end
        if (busy) busy_cycles++;
        checks++;
        if (busy_cycles !== 8) begin
            errors++;
            $display("FAIL full_busy_cycles: got %0d expected %0d", busy_cycles, 8);
        end
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL full_idle: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_reset_send();
        @(negedge clk);
        in_vec = 8'hF0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b1010_0100) begin
            errors++;
            $display("FAIL rst_send_first: got %b expected %b", obs, 8'b1010_0100);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL rst_send_during: got %b expected %b", obs, 8'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL rst_send_after: got %b expected %b", obs, 8'b0100_0000);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL rst_send_no_beat: got %b expected %b", obs, 8'b0100_0000);
        end
        in_vec = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 8'b1011_0000) begin
            errors++;
            $display("FAIL rst_send_next: got %b expected %b", obs, 8'b1011_0000);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL rst_send_next_idle: got %b expected %b", obs, 8'b0100_0000);
        end
    endtask

    task automatic test_w64();
        @(negedge clk);
        in_vec64 = 64'h8000_0000_0000_0000; in_valid64 = 1'b1; out_ready64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        checks++;
        if ({out_valid64, out_last64, out_empty64, out_code64} !== {3'b110, 6'd63}) begin
            errors++;
            $display("FAIL w64_top_bit: got %b expected %b",
                     {out_valid64, out_last64, out_empty64, out_code64}, {3'b110, 6'd63});
        end
        in_vec64 = 64'h8000_0000_0000_0001; in_valid64 = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({out_valid64, in_ready64} !== 2'b01) begin
            errors++;
            $display("FAIL w64_idle: got %b expected %b", {out_valid64, in_ready64}, 2'b01);
        end
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        checks++;
        if ({out_valid64, out_last64, out_code64} !== {2'b10, 6'd0}) begin
            errors++;
            $display("FAIL w64_pair_first: got %b expected %b",
                     {out_valid64, out_last64, out_code64}, {2'b10, 6'd0});
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid64, out_last64, out_code64} !== {2'b11, 6'd63}) begin
            errors++;
            $display("FAIL w64_pair_second: got %b expected %b",
                     {out_valid64, out_last64, out_code64}, {2'b11, 6'd63});
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid64, in_ready64, busy64} !== 3'b010) begin
            errors++;
            $display("FAIL w64_pair_idle: got %b expected %b",
                     {out_valid64, in_ready64, busy64}, 3'b010);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b0;
        in_valid64  = 1'b0;
        in_vec64    = '0;
        out_ready64 = 1'b0;

        test_reset();
        test_mid_vector();
        test_backpressure();
        test_zero();
        test_full();
        test_reset_send();
        test_w64();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_code_tx.md
# onehot_code_tx

Transmit side of the one-hot/binary command path. Accepts a request vector over a valid/ready input handshake and emits the binary index of every set bit, lowest index first, one code per output beat. A vector with no bits set produces a single flagged empty beat, so the downstream case-style decoder always receives a defined terminating beat. Sits between request-generating logic and the binary-code decoder.

## Interface
- `W`, 8, request vector width; legal range 2..64.
- `CW`, `$clog2(W)`, code width; derived, not overridden.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  request vector valid.
- `in_ready`  output  1  block can accept a vector.
- `in_vec`  input  W  request vector; bit i set means code i is requested.
- `out_valid`  output  1  `out_code` beat valid.
- `out_ready`  input  1  downstream accepts the beat.
- `out_code`  output  CW  binary index of the current lowest pending bit.
- `out_last`  output  1  final beat of the current vector.
- `out_empty`  output  1  beat carries no code because the input vector was all zero.
- `busy`  output  1  a vector is held and not fully transmitted.

## Operation
- Two states:
  - **IDLE**: `in_ready=1`, `out_valid=0`.
  - **SEND**: `in_ready=0`, `out_valid=1`.
- **IDLE -> SEND**: on `in_valid && in_ready`.
  - Latch `in_vec` into the `pend` register.
  - Set `empty_q = (in_vec == 0)`.
- **SEND outputs**:
  - `out_code` = index of the lowest set bit of `pend`. It is 0 when `pend == 0`.
  - `out_last` = 1 when `pend` has at most one bit set.
  - `out_empty` = `empty_q`.
- **SEND beat accepted** (`out_valid && out_ready`):
  - Clear the lowest set bit of `pend`: `pend <= pend & (pend - 1)`.
  - If `out_last`, go to IDLE and clear `empty_q`.
- **SEND stall**: while `out_ready=0`, `out_code`, `out_last`, `out_empty` and `pend` hold stable.
- `busy` = state is SEND.
- **Decode completeness**:
  - Every state decode and the priority encode has an explicit default path.
  - Undefined state encodings return to IDLE with outputs deasserted.
  - No combinational output may infer a latch.
- Input vectors are not checked for one-hot-ness; multi-hot vectors are the normal case.

## Timing
- **Reset**, applied on any cycle including mid-vector:
  - Next edge sets state=IDLE, `pend=0`, `empty_q=0`.
  - The in-flight vector is dropped with no further beats.
  - While `rst=1`: `in_ready=0`, `out_valid=0`, `out_code=0`, `out_last=0`, `out_empty=0`, `busy=0`.
  - `in_ready=1` in the first cycle after `rst` deasserts.
- **Latency**: vector accepted at edge N -> first beat has `out_valid=1` in cycle N+1.
- **Throughput**: with `out_ready` held high, a vector with k set bits takes k beats on consecutive cycles. An all-zero vector takes 1 beat.
- **Return to IDLE**: after the last handshake at edge M, `in_ready=1` in cycle M+1. The next vector is accepted no earlier than edge M+1.
  - Minimum occupancy per vector is therefore k+1 cycles.
- **No bypass**: `in_ready` depends only on state, never combinationally on `out_ready`.
- **Width rule**: `CW = $clog2(W)`. Bit W-1 encodes as W-1 with no truncation. Codes never exceed W-1.
- **Ignored input**: `in_valid` is ignored in SEND. The source must hold `in_vec` until it sees `in_ready`.

## Test plan
- **Reset mid-vector**: reset, then `in_vec=8'b0010_0101`, `out_ready=1`.
  - Required beats: codes 0, 2, 5 on cycles N+1..N+3; `out_last` only on code 5; `in_ready=1` in cycle N+4.
- **Backpressure**: `in_vec=8'b1000_0010`, `out_ready` toggling 0,1,0,0,1.
  - Codes 1 then 7; values stable during stalls; exactly 2 handshakes.
- **Zero vector**: `in_vec=0`.
  - Single beat: `out_code=0`, `out_empty=1`, `out_last=1`; then IDLE.
- **Full vector**: `in_vec=8'hFF`, `out_ready=1`.
  - 8 consecutive beats with codes 0..7; `out_last` on 7 only; `busy` high for 8 cycles.
- **Reset during SEND**: `in_vec=8'hF0`, assert `rst` after the first beat.
  - No further beats; all outputs at reset values; next vector `8'h01` yields a single beat with code 0 and `out_last=1`.
- **W=64 width check**: `in_vec` = bit 63 only.
  - `out_code=6'd63`, `out_last=1`.
